// File: rtl/obuftds_stim_gen_pkg.sv
// Shared types and width helpers for the OBUFTDS stimulus generator.
// Mode encoding is fixed; 2'd3 is never produced and is treated as an illegal state.
package obuftds_stim_pkg;

  typedef enum logic [1:0] {
    ModeStatic = 2'd0,
    ModeBlink  = 2'd1,
    ModeWalk   = 2'd2
  } mode_t;

  // Width needed to hold counts 0..n inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obuftds_stim_gen_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input bit.
// The output flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module switch_debounce
  import obuftds_stim_pkg::*;
#(
  parameter logic        RESET_VAL       = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            dout_q;
  logic            dout_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Synchroniser flops reset to the debounced reset level so nothing is seen as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (sync2_q != dout_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        dout_d = ~dout_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/obuftds_stim_gen.sv
// Stimulus generator for a bank of OBUFTDS buffers: debounced switches and a mode button
// drive registered data/tri-state per channel in static, blink or walking-one modes.
module obuftds_stim_gen
  import obuftds_stim_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV       = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sw_data,
  input  logic [NUM_CH-1:0] sw_tri,
  input  logic              btn_mode,
  output logic [NUM_CH-1:0] buf_i,
  output logic [NUM_CH-1:0] buf_t,
  output logic [1:0]        mode
);

  localparam int unsigned NumIn = 2 * NUM_CH + 1;
  localparam int unsigned PreW  = idx_width(BLINK_DIV);
  localparam int unsigned WalkW = idx_width(NUM_CH);

  // Input conditioning: bits [NUM_CH-1:0] data, [2*NUM_CH-1:NUM_CH] tri, top bit button.
  logic [NumIn-1:0]  raw_in;
  logic [NumIn-1:0]  db_in;
  logic [NUM_CH-1:0] data_db;
  logic [NUM_CH-1:0] tri_db;
  logic              btn_db;

  assign raw_in = {btn_mode, sw_tri, sw_data};

  for (genvar i = 0; i < NumIn; i++) begin : g_db
    switch_debounce #(
      .RESET_VAL      (((i >= NUM_CH) && (i < 2 * NUM_CH)) ? 1'b1 : 1'b0),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (raw_in[i]),
      .dout(db_in[i])
    );
  end

  assign data_db = db_in[NUM_CH-1:0];
  assign tri_db  = db_in[2*NUM_CH-1:NUM_CH];
  assign btn_db  = db_in[2*NUM_CH];

  // Button edge detect
  logic btn_prev_q;
  logic btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_db;
    end
  end

  assign btn_rise = btn_db & ~btn_prev_q;

  // Mode FSM: state register
  mode_t mode_q;
  mode_t mode_d;
  logic  mode_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= ModeStatic;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode FSM: next state; the unused encoding falls back to static.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      ModeStatic: if (btn_rise) mode_d = ModeBlink;
      ModeBlink:  if (btn_rise) mode_d = ModeWalk;
      ModeWalk:   if (btn_rise) mode_d = ModeStatic;
      default:    mode_d = ModeStatic;
    endcase
  end

  assign mode_change = (mode_d != mode_q);

  // Prescaler, blink phase and walk index; a mode change overrides a same-cycle tick.
  logic [PreW-1:0]  presc_q;
  logic [PreW-1:0]  presc_d;
  logic             tick;
  logic             phase_q;
  logic             phase_d;
  logic [WalkW-1:0] walk_idx_q;
  logic [WalkW-1:0] walk_idx_d;

  assign tick = (presc_q == PreW'(BLINK_DIV - 1));

  always_comb begin
    presc_d    = presc_q + PreW'(1);
    phase_d    = phase_q;
    walk_idx_d = walk_idx_q;
    if (mode_change) begin
      presc_d    = '0;
      phase_d    = 1'b0;
      walk_idx_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (mode_q == ModeBlink) begin
        phase_d = ~phase_q;
      end
      if (mode_q == ModeWalk) begin
        if (walk_idx_q == WalkW'(NUM_CH - 1)) begin
          walk_idx_d = '0;
        end else begin
          walk_idx_d = walk_idx_q + WalkW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      phase_q    <= 1'b0;
      walk_idx_q <= '0;
    end else begin
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      walk_idx_q <= walk_idx_d;
    end
  end

  // Mode FSM: outputs. Tri-state follows the switches regardless of mode.
  logic [NUM_CH-1:0] buf_i_d;
  logic [NUM_CH-1:0] buf_i_q;
  logic [NUM_CH-1:0] buf_t_q;

  always_comb begin
    buf_i_d = data_db;
    unique case (mode_q)
      ModeBlink: buf_i_d = data_db ^ {NUM_CH{phase_q}};
      ModeWalk: begin
        for (int k = 0; k < NUM_CH; k++) begin
          buf_i_d[k] = (WalkW'(k) == walk_idx_q);
        end
      end
      default: buf_i_d = data_db;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_i_q <= '0;
      buf_t_q <= '1;
    end else begin
      buf_i_q <= buf_i_d;
      buf_t_q <= tri_db;
    end
  end

  assign buf_i = buf_i_q;
  assign buf_t = buf_t_q;
  assign mode  = mode_q;

endmodule
